// File: rtl/mem_stage_lsu.sv
// Memory-access stage: req/ack data-memory handshake, store lane alignment, load extension, MEM/WB register.
// Optional MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of issuing them.
module mem_stage_lsu (
  input  logic        clk,
  input  logic        nrst,
  input  logic        mem_valid,
  input  logic [31:0] mem_ALUout,
  input  logic [31:0] mem_storedata,
  input  logic [3:0]  mem_dm_write,
  input  logic [2:0]  mem_dm_select,
  input  logic [1:0]  mem_sel_data,
  input  logic [11:0] mem_pc4,
  input  logic [31:0] mem_imm,
  input  logic [4:0]  mem_rd,
  input  logic        mem_wr_en,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        wb_wr_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mis_trap
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      r_state;
  logic [1:0]  w_off;
  logic        w_is_store;
  logic        w_access;
  logic        w_mis;
  logic        w_idle;
  logic        w_issue;
  logic [31:0] w_shift;
  logic [31:0] w_load;
  logic [31:0] w_wb_sel;

  assign w_off      = mem_ALUout[1:0];
  assign w_is_store = |mem_dm_write;
  assign w_access   = mem_valid & (w_is_store | (mem_sel_data == 2'b01));

`ifdef MISALIGN_TRAP_EN
  logic w_is_load;
  logic w_half;
  logic w_word;
  assign w_is_load = ~w_is_store & (mem_sel_data == 2'b01);
  assign w_half    = (mem_dm_write == 4'b0011) | (w_is_load & (mem_dm_select[1:0] == 2'b01));
  assign w_word    = (mem_dm_write == 4'b1111) | (w_is_load & (mem_dm_select == 3'b010));
  assign w_mis     = w_access & ((w_half & w_off[0]) | (w_word & (|w_off)));
`else
  assign w_mis     = 1'b0;
`endif

  assign w_idle  = (r_state == IDLE);
  assign w_issue = w_idle & w_access & ~w_mis;

  // Request and stall drop immediately under reset so a stuck WAIT never leaks out.
  assign dm_req   = nrst & (w_issue | ~w_idle);
  assign stall    = nrst & (w_issue | (~w_idle & ~dm_ack));
  assign dm_addr  = {mem_ALUout[31:2], 2'b00};
  assign dm_we    = mem_dm_write << w_off;
  assign dm_wdata = mem_storedata << {w_off, 3'b000};

  assign w_shift = dm_rdata >> {w_off, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (mem_dm_select)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b101:  w_load = {16'd0, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  always_comb begin
    w_wb_sel = mem_ALUout;
    case (mem_sel_data)
      2'b00:   w_wb_sel = mem_ALUout;
      2'b01:   w_wb_sel = w_load;
      2'b10:   w_wb_sel = {20'd0, mem_pc4};
      default: w_wb_sel = mem_imm;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state  <= IDLE;
      wb_wr_en <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
      mis_trap <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (w_issue) r_state <= WAIT;
        WAIT:    if (dm_ack)  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      mis_trap <= w_idle & w_mis;
      if (stall) begin
        wb_wr_en <= 1'b0;
      end else begin
        wb_wr_en <= mem_valid & mem_wr_en & ~w_mis;
        wb_rd    <= mem_rd;
        wb_data  <= w_wb_sel;
      end
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-access stage of the RV32IMC pipeline. It sits directly downstream of the EXE/MEM pipeline register and consumes its outputs. It performs loads and stores against a variable-latency data memory using a req/ack handshake, and stalls the upstream pipeline while an access is outstanding. It also aligns store data and byte enables, sign- or zero-extends load data, and registers the write-back result into the MEM/WB boundary.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  reset, synchronous, active-low.
- mem_valid  in  1  instruction present in MEM.
- mem_ALUout  in  32  effective address, or ALU result.
- mem_storedata  in  32  store data, right-justified.
- mem_dm_write  in  4  unshifted store mask: 0000 = no store, 0001 = SB, 0011 = SH, 1111 = SW.
- mem_dm_select  in  3  load type (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_sel_data  in  2  write-back source: 00 ALU, 01 load, 10 pc4, 11 imm.
- mem_pc4  in  12  PC+4.
- mem_imm  in  32  immediate.
- mem_rd  in  5  destination register.
- mem_wr_en  in  1  register-file write enable.
- dm_req  out  1  memory request.
- dm_addr  out  32  word address: {mem_ALUout[31:2], 2'b00}.
- dm_we  out  4  byte write enables; 0000 = read.
- dm_wdata  out  32  lane-aligned store data.
- dm_ack  in  1  access complete; dm_rdata valid in the same cycle.
- dm_rdata  in  32  read word.
- stall  out  1  freezes the PC, IF/ID, ID/EXE and EXE/MEM registers.
- wb_wr_en  out  1  registered write enable.
- wb_rd  out  5  registered destination register.
- wb_data  out  32  registered write-back value.
- mis_trap  out  1  registered misaligned-access pulse.

## Operation
- Access = mem_valid & (mem_dm_write != 0 | mem_sel_data == 01).
- FSM states:
  - IDLE → WAIT when an access is issued.
  - WAIT → IDLE on dm_ack.
  - Any state → IDLE on reset.
- dm_req = nrst & ((IDLE & access & ~misaligned) | WAIT).
- dm_addr, dm_we and dm_wdata are driven combinationally from the mem_* inputs. Upstream holds those inputs stable while stall is high.
- Store alignment, with o = mem_ALUout[1:0]:
  - dm_we = (mem_dm_write << o)[3:0].
  - dm_wdata = mem_storedata << 8·o.
- For loads, dm_we = 0000.
- Load extraction: s = dm_rdata >> 8·o. Result by load type:
  - LB: sext(s[7:0]).
  - LBU: zext(s[7:0]).
  - LH: sext(s[15:0]).
  - LHU: zext(s[15:0]).
  - LW: s.
  - Any other dm_select value: s.
- Write-back select:
  - 00 → mem_ALUout.
  - 01 → load result.
  - 10 → zext(mem_pc4).
  - 11 → mem_imm.
- stall = (IDLE & access & ~misaligned) | (WAIT & ~dm_ack).
- WB register update at each clock edge:
  - If stall is high: wb_wr_en ← 0 (bubble). wb_rd and wb_data hold.
  - Otherwise: wb_wr_en ← mem_valid & mem_wr_en, wb_rd ← mem_rd, wb_data ← selected value.
- Stores write back only when mem_wr_en is set. mem_wr_en is normally 0 for stores.
- Without MISALIGN_TRAP_EN, misaligned is the constant 0.

## Timing
- Reset values: state IDLE, dm_req 0, stall 0, wb_wr_en 0, wb_rd 0, wb_data 0, mis_trap 0.
- Non-memory instruction: occupies MEM for 1 cycle, no stall. WB outputs are valid after the next edge.
- Memory access:
  - Minimum 2 cycles: the request cycle plus the ack cycle.
  - dm_ack is ignored in IDLE, so the earliest useful ack is the cycle after dm_req first rises.
  - Each additional wait cycle adds one stall cycle.
- The ack cycle has stall = 0. The WB register captures the result and upstream advances on the same edge.
- A new access may issue in the cycle immediately after the ack cycle, back-to-back with no idle cycle.
- dm_req stays high continuously from issue through the ack cycle.
- Reset mid-WAIT:
  - dm_req drops in the same cycle.
  - FSM returns to IDLE.
  - A late dm_ack arriving in IDLE is ignored.
- mem_valid = 0 in IDLE: no request is issued and wb_wr_en ← 0.

## Configuration
- MISALIGN_TRAP_EN defined:
  - misaligned = access & ((halfword & o[0]) | (word & o != 00)). Halfword covers SH/LH/LHU; word covers SW/LW.
  - A misaligned access issues no dm_req and no stall.
  - mis_trap ← 1 for one cycle; wb_wr_en ← 0.
- MISALIGN_TRAP_EN undefined:
  - mis_trap is tied to 0.
  - Misaligned accesses are issued. Lane shifts wrap within the word, with byte enables truncated to 4 bits (e.g. SW at offset 2 → dm_we 1100).

## Test plan
- LW at address 0x104, dm_rdata 0xDEADBEEF, ack 1 cycle after the request → dm_addr 0x104, stall high for exactly 1 cycle, wb_data 0xDEADBEEF, wb_wr_en 1.
- LB at address 0x203, dm_rdata 0x80FF_0000 → wb_data 0xFFFFFF80. The same access as LBU → wb_data 0x00000080.
- SH at address 0x302, storedata 0x0000ABCD → dm_we 1100, dm_wdata 0xABCD0000. dm_ack withheld for 3 cycles → stall high for 4 cycles and wb_wr_en 0 throughout.
- JAL write-back with sel_data 10, pc4 0x0A4 → no dm_req, no stall, wb_data 0x000000A4 one cycle later.
- Reset asserted in WAIT with dm_ack arriving the cycle after reset releases → dm_req 0, stall 0, all WB outputs 0, ack ignored.
- With MISALIGN_TRAP_EN, LW at 0x101 → dm_req stays 0, mis_trap pulses for 1 cycle, wb_wr_en 0. Without the macro, the same LW issues with dm_addr 0x100.
